// File: rtl/rainbow_pkg.sv
// Shared definitions for the rainbow pattern generator.
//   HUE_MAX / HUE_W : hue wheel size (0..767) and width
//   PIXEL_W         : bits per packed {G,R,B} pixel
//   mode_e          : frame modes, state_e : generator FSM states
//   hue_add         : modular hue addition without a modulo operator
package rainbow_pkg;

  localparam int unsigned HUE_MAX = 768;
  localparam int unsigned HUE_W   = 10;
  localparam int unsigned PIXEL_W = 24;

  typedef enum logic [1:0] {
    ModeHold    = 2'd0,
    ModeRainbow = 2'd1,
    ModeSolid   = 2'd2,
    ModeChase   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCalc   = 2'd1,
    StCommit = 2'd2
  } state_e;

  // Both operands are below HUE_MAX, so one conditional subtract wraps the sum.
  function automatic logic [HUE_W-1:0] hue_add(input logic [HUE_W-1:0] a,
                                               input logic [HUE_W-1:0] b);
    logic [HUE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (HUE_W+1)'(HUE_MAX)) begin
      sum = sum - (HUE_W+1)'(HUE_MAX);
    end
    return sum[HUE_W-1:0];
  endfunction

endpackage

// File: rtl/rainbow_pattern_gen_if.sv
// Control/frame bundle between a controller and the rainbow pattern generator.
//   tickIn      : slow update strobe/level (rising edge counts)
//   mode        : frame mode, sampled at frame start
//   brightShift : per-channel right shift, sampled at frame start
//   colorOut    : packed frame, LED i at [24i+23:24i] as {G,R,B}
//   frameValid  : one-cycle pulse when colorOut updates
//   busy        : frame computation in progress
// master = controller side, slave = generator side.
interface rainbow_pattern_gen_if
  import rainbow_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 4
);
  logic                          tickIn;
  logic [1:0]                    mode;
  logic [2:0]                    brightShift;
  logic [PIXEL_W*NUM_LEDS-1:0]   colorOut;
  logic                          frameValid;
  logic                          busy;

  modport master (
    output tickIn, mode, brightShift,
    input  colorOut, frameValid, busy
  );

  modport slave (
    input  tickIn, mode, brightShift,
    output colorOut, frameValid, busy
  );
endinterface

// File: rtl/hue_to_grb.sv
// Colour wheel: maps a hue in 0..767 to a {G,R,B} pixel, then dims every
// channel by a right shift.
//   i_hue   : hue, 0..767 (values above 767 give black)
//   i_shift : brightness right-shift, 0..7
//   o_grb   : {G,R,B} pixel
module hue_to_grb
  import rainbow_pkg::*;
(
  input  logic [HUE_W-1:0]   i_hue,
  input  logic [2:0]         i_shift,
  output logic [PIXEL_W-1:0] o_grb
);

  logic [7:0] w_r;
  logic [7:0] w_g;
  logic [7:0] w_b;
  logic [7:0] w_lo;

  // Within each 256-wide segment, "255 - offset" is just the inverted low byte.
  assign w_lo = i_hue[7:0];

  always_comb begin
    w_r = 8'd0;
    w_g = 8'd0;
    w_b = 8'd0;
    unique case (i_hue[9:8])
      2'd0: begin
        w_r = ~w_lo;
        w_g = w_lo;
      end
      2'd1: begin
        w_g = ~w_lo;
        w_b = w_lo;
      end
      2'd2: begin
        w_b = ~w_lo;
        w_r = w_lo;
      end
      default: ;
    endcase
  end

  assign o_grb = {w_g >> i_shift, w_r >> i_shift, w_b >> i_shift};

endmodule

// File: rtl/rainbow_pattern_gen.sv
// Rainbow pattern generator for a WS2812B chain.
// Each rising edge of bus.tickIn starts a frame: one LED is computed per clock
// into a shadow buffer, then the whole frame is committed to bus.colorOut at once
// with a one-cycle bus.frameValid pulse. A tick arriving mid-frame is remembered
// (at most one) and starts the next frame as soon as the generator is idle.
//   clk   : system clock
//   reset : synchronous, active-low reset
//   bus   : rainbow_pattern_gen_if slave (tick/mode/shift in, frame/status out)
// NUM_LEDS must match the NUM_LEDS of the connected interface.
module rainbow_pattern_gen
  import rainbow_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = 4,
  parameter int unsigned HUE_STEP    = 8,
  parameter int unsigned LED_SPACING = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  rainbow_pattern_gen_if.slave  bus
);

  localparam int unsigned     IdxW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_LEDS - 1);
  localparam logic [HUE_W-1:0] HueStep    = HUE_W'(HUE_STEP);
  localparam logic [HUE_W-1:0] LedSpacing = HUE_W'(LED_SPACING);

  state_e                      r_state;
  mode_e                       r_mode;
  logic [2:0]                  r_shift;
  logic [HUE_W-1:0]            r_base_hue;
  logic [HUE_W-1:0]            r_led_hue;
  logic [IdxW-1:0]             r_idx;
  logic [IdxW-1:0]             r_chase_pos;
  logic                        r_pending;
  logic                        r_tick_prev;
  logic [PIXEL_W*NUM_LEDS-1:0] r_color;
  logic                        r_frame_valid;
  logic [PIXEL_W-1:0]          r_shadow [NUM_LEDS];

  logic                        w_tick_rise;
  logic [HUE_W-1:0]            w_next_base;
  logic [PIXEL_W-1:0]          w_grb;
  logic [PIXEL_W-1:0]          w_pixel;
  logic [PIXEL_W*NUM_LEDS-1:0] w_shadow_flat;
  mode_e                       w_mode_in;

  assign w_tick_rise = bus.tickIn & ~r_tick_prev;
  assign w_next_base = hue_add(r_base_hue, HueStep);
  assign w_mode_in   = mode_e'(bus.mode);

  hue_to_grb u_hue_to_grb (
    .i_hue   (r_led_hue),
    .i_shift (r_shift),
    .o_grb   (w_grb)
  );

  // In chase mode only the LED at the chase position is lit.
  assign w_pixel = (r_mode == ModeChase && r_idx != r_chase_pos) ? '0 : w_grb;

  always_comb begin
    w_shadow_flat = '0;
    for (int i = 0; i < int'(NUM_LEDS); i++) begin
      w_shadow_flat[i*PIXEL_W +: PIXEL_W] = r_shadow[i];
    end
  end

  // Shadow buffer needs no reset: it is fully rewritten before every commit.
  always_ff @(posedge clk) begin
    if (r_state == StCalc) begin
      r_shadow[r_idx] <= w_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_mode        <= ModeHold;
      r_shift       <= 3'd0;
      r_base_hue    <= '0;
      r_led_hue     <= '0;
      r_idx         <= '0;
      r_chase_pos   <= '0;
      r_pending     <= 1'b0;
      r_tick_prev   <= 1'b0;
      r_color       <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_tick_prev   <= bus.tickIn;
      r_frame_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_tick_rise || r_pending) begin
            r_pending <= 1'b0;
            r_mode    <= w_mode_in;
            r_shift   <= bus.brightShift;
            r_idx     <= '0;
            if (w_mode_in == ModeHold) begin
              r_led_hue <= r_base_hue;
            end else begin
              r_base_hue <= w_next_base;
              r_led_hue  <= w_next_base;
            end
            if (w_mode_in == ModeChase) begin
              r_chase_pos <= (r_chase_pos == LastIdx) ? '0 : r_chase_pos + 1'b1;
            end
            r_state <= StCalc;
          end
        end
        StCalc: begin
          if (w_tick_rise) begin
            r_pending <= 1'b1;
          end
          if (r_mode == ModeRainbow) begin
            r_led_hue <= hue_add(r_led_hue, LedSpacing);
          end
          if (r_idx == LastIdx) begin
            r_state <= StCommit;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        StCommit: begin
          if (w_tick_rise) begin
            r_pending <= 1'b1;
          end
          r_color       <= w_shadow_flat;
          r_frame_valid <= 1'b1;
          r_state       <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.colorOut   = r_color;
  assign bus.frameValid = r_frame_valid;
  assign bus.busy       = (r_state != StIdle);

endmodule

// File: tb/tb_rainbow_pattern_gen.sv
module tb_rainbow_pattern_gen;

  logic clk;
  logic reset;

  rainbow_pattern_gen_if #(.NUM_LEDS(4)) bus ();

  rainbow_pattern_gen #(
    .NUM_LEDS    (4),
    .HUE_STEP    (8),
    .LED_SPACING (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fv_count = 0;

  always @(negedge clk) begin
    if (bus.frameValid) fv_count++;
  end

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  shift;
    logic [95:0] frame;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.tickIn = 1'b0;
    step(3);
    reset = 1'b1;
  endtask

  // Pulse a one-cycle tick and wait for the commit; lat counts edges after start.
  task automatic run_frame(output int lat);
    bus.tickIn = 1'b1;
    step(1);
    bus.tickIn = 1'b0;
    lat = 0;
    while (!bus.frameValid && lat < 50) begin
      step(1);
      lat++;
    end
  endtask

  int lat;
  int fv0;

  initial begin
    vecs[0] = '{2'd1, 3'd0, 96'hC83700_887700_48B700_08F700};
    vecs[1] = '{2'd1, 3'd2, 96'h320D00_221D00_122D00_023D00};
    vecs[2] = '{2'd2, 3'd0, 96'h08F700_08F700_08F700_08F700};
    vecs[3] = '{2'd3, 3'd0, 96'h000000_000000_08F700_000000};
    vecs[4] = '{2'd0, 3'd0, 96'h00FF00_00FF00_00FF00_00FF00};
    vecs[5] = '{2'd2, 3'd7, 96'h000100_000100_000100_000100};

    bus.mode = 2'd1;
    bus.brightShift = 3'd0;
    bus.tickIn = 1'b0;
    reset = 1'b0;

    // Reset and idle
    do_reset();
    step(50);
    chk("idle_color", 96'(bus.colorOut), 96'h0);
    chk("idle_fv_count", 96'(fv_count), 96'd0);
    chk("idle_busy", 96'(bus.busy), 96'd0);

    // Table: one tick from reset in each mode/shift
    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.mode = vecs[i].mode;
      bus.brightShift = vecs[i].shift;
      step(2);
      run_frame(lat);
      chk($sformatf("vec%0d_latency", i), 96'(lat), 96'd5);
      chk($sformatf("vec%0d_frame", i), 96'(bus.colorOut), vecs[i].frame);
      step(1);
      chk($sformatf("vec%0d_fv_width", i), 96'(bus.frameValid), 96'd0);
      chk($sformatf("vec%0d_busy_after", i), 96'(bus.busy), 96'd0);
    end

    // 96 rainbow ticks wrap the base hue back to 0
    do_reset();
    bus.mode = 2'd1;
    bus.brightShift = 3'd0;
    for (int i = 0; i < 96; i++) begin
      run_frame(lat);
      step(2);
    end
    chk("wrap_led0", 96'(bus.colorOut[23:0]), 96'h00FF00);
    chk("wrap_led1", 96'(bus.colorOut[47:24]), 96'h40BF00);

    // Chase: position advances and wraps; a long-held tick counts once
    do_reset();
    bus.mode = 2'd3;
    for (int i = 0; i < 4; i++) begin
      run_frame(lat);
      step(2);
    end
    chk("chase4_frame", 96'(bus.colorOut), 96'h000000_000000_000000_20DF00);
    fv0 = fv_count;
    bus.tickIn = 1'b1;
    step(100);
    bus.tickIn = 1'b0;
    step(10);
    chk("chase_level_once", 96'(fv_count - fv0), 96'd1);
    chk("chase5_frame", 96'(bus.colorOut), 96'h000000_000000_28D700_000000);

    // Pending: second tick queued, third dropped
    do_reset();
    bus.mode = 2'd1;
    fv0 = fv_count;
    bus.tickIn = 1'b1; step(1);
    chk("pend_busy", 96'(bus.busy), 96'd1);
    bus.tickIn = 1'b0; step(1);
    bus.tickIn = 1'b1; step(1);
    bus.tickIn = 1'b0; step(1);
    bus.tickIn = 1'b1; step(1);
    bus.tickIn = 1'b0; step(30);
    chk("pend_fv_count", 96'(fv_count - fv0), 96'd2);
    chk("pend_led0", 96'(bus.colorOut[23:0]), 96'h10EF00);

    // Mode change mid-frame has no effect on the running frame
    do_reset();
    bus.mode = 2'd2;
    bus.tickIn = 1'b1; step(1);
    bus.tickIn = 1'b0;
    bus.mode = 2'd1;
    bus.brightShift = 3'd3;
    step(10);
    chk("midframe_mode", 96'(bus.colorOut), 96'h08F700_08F700_08F700_08F700);
    bus.brightShift = 3'd0;

    // Reset during CALC aborts the frame
    do_reset();
    bus.mode = 2'd1;
    run_frame(lat);
    step(2);
    chk("abort_pre_color", 96'(bus.colorOut[23:0]), 96'h08F700);
    bus.tickIn = 1'b1; step(1);
    bus.tickIn = 1'b0; step(1);
    fv0 = fv_count;
    reset = 1'b0; step(1);
    chk("abort_color", 96'(bus.colorOut), 96'h0);
    chk("abort_busy", 96'(bus.busy), 96'd0);
    reset = 1'b1;
    step(20);
    chk("abort_no_fv", 96'(fv_count - fv0), 96'd0);
    chk("abort_color_hold", 96'(bus.colorOut), 96'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
